// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: handshake and status bundle between a producer/consumer
// and the fifo_sync_param block. WIDTH is the data width, ADDR the pointer
// width (occupancy count is ADDR+1 bits).
interface fifo_sync_param_if #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 3
);
    logic             wen;
    logic             ren;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [ADDR:0]    count;
    logic             overflow;
    logic             underflow;

    // Producer/consumer side: issues requests and write data, observes status.
    modport master (
        output wen,
        output ren,
        output data_in,
        input  data_out,
        input  full,
        input  empty,
        input  almost_full,
        input  almost_empty,
        input  count,
        input  overflow,
        input  underflow
    );

    // FIFO side: accepts requests, drives data and status.
    modport slave (
        input  wen,
        input  ren,
        input  data_in,
        output data_out,
        output full,
        output empty,
        output almost_full,
        output almost_empty,
        output count,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds and one-cycle
// overflow/underflow pulses for rejected accesses.
// Optional feature macro FIFO_FWFT_EN: when defined, data_out shows the head
// word combinationally (first-word-fall-through) and ren acts as a pop; when
// undefined, data_out is a register loaded on each accepted read.
// A read and a write in the same cycle at full both proceed (the freed slot is
// rewritten); at empty only the write proceeds and underflow pulses.
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR     = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             reset,
    fifo_sync_param_if.slave bus
);

    localparam logic [ADDR:0]   CNT_FULL = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0]   CNT_AF   = (ADDR+1)'(AF_LEVEL);
    localparam logic [ADDR:0]   CNT_AE   = (ADDR+1)'(AE_LEVEL);
    localparam logic [ADDR:0]   CNT_ONE  = (ADDR+1)'(1);
    localparam logic [ADDR-1:0] PTR_ONE  = ADDR'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [ADDR-1:0]  wrPtr_q, wrPtr_d;
    logic [ADDR-1:0]  rdPtr_q, rdPtr_d;
    logic [ADDR:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             isFull;
    logic             isEmpty;
    logic             rdAcc;
    logic             wrAcc;

    assign isFull  = (count_q == CNT_FULL);
    assign isEmpty = (count_q == '0);
    assign rdAcc   = bus.ren && !isEmpty;
    assign wrAcc   = bus.wen && (!isFull || rdAcc);

    // Next-state for pointers, occupancy and the error pulses.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        overflow_d  = bus.wen && isFull && !rdAcc;
        underflow_d = bus.ren && isEmpty;
        if (wrAcc) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end
        if (rdAcc) begin
            rdPtr_d = rdPtr_q + PTR_ONE;
        end
        if (wrAcc && !rdAcc) begin
            count_d = count_q + CNT_ONE;
        end else if (rdAcc && !wrAcc) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Control state register; reset discards contents and ignores same-cycle requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array: not reset, written only on an accepted write.
    always_ff @(posedge clk) begin
        if (!reset && wrAcc) begin
            mem[wrPtr_q] <= bus.data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.data_out = mem[rdPtr_q];
`else
    logic [WIDTH-1:0] dataOut_q;

    // Registered read data: loads the head word on an accepted read, else holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            dataOut_q <= '0;
        end else if (rdAcc) begin
            dataOut_q <= mem[rdPtr_q];
        end
    end

    assign bus.data_out = dataOut_q;
`endif

    assign bus.count        = count_q;
    assign bus.full         = isFull;
    assign bus.empty        = isEmpty;
    assign bus.almost_full  = (count_q >= CNT_AF);
    assign bus.almost_empty = (count_q <= CNT_AE);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed self-checking bench for fifo_sync_param with
// default parameters (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2).
// Data checks adapt to FIFO_FWFT_EN (head word visible before the pop edge).
module tb_fifo_sync_param;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fifo_sync_param_if #(.WIDTH(8), .ADDR(3)) bus ();

    fifo_sync_param #(
        .WIDTH(8), .DEPTH(8), .ADDR(3), .AF_LEVEL(6), .AE_LEVEL(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] fillVals [8] = '{8'd10, 8'd5, 8'd6, 8'd7, 8'd89, 8'd125, 8'd3, 8'd9};
    logic [7:0] wrapVals [8] = '{8'd5, 8'd6, 8'd7, 8'd89, 8'd125, 8'd3, 8'd9, 8'd220};
    // count after each fill write, and flags at that count
    logic [3:0] fillCnt  [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    logic       fillAf   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       fillFull [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    // count after each drain read, and almost_empty/empty at that count
    logic [3:0] drainCnt [8] = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    logic       drainAe  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       drainEmp [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Drive one cycle of requests, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic w, input logic r, input logic [7:0] d);
        bus.wen     = w;
        bus.ren     = r;
        bus.data_in = d;
        @(posedge clk);
        #1;
        bus.wen     = 1'b0;
        bus.ren     = 1'b0;
        bus.data_in = 8'd0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic fillEight();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, fillVals[i]);
            checkOutput($sformatf("fill_count_%0d", i), 32'(bus.count), 32'(fillCnt[i]));
            checkOutput($sformatf("fill_af_%0d", i), 32'(bus.almost_full), 32'(fillAf[i]));
            checkOutput($sformatf("fill_full_%0d", i), 32'(bus.full), 32'(fillFull[i]));
            checkOutput($sformatf("fill_empty_%0d", i), 32'(bus.empty), 32'd0);
        end
    endtask

    // Pop one word and check the word it delivers in the active mode.
    task automatic readCheck(input string tag, input logic [7:0] expWord);
`ifdef FIFO_FWFT_EN
        checkOutput(tag, 32'(bus.data_out), 32'(expWord));
        applyStimulus(1'b0, 1'b1, 8'd0);
`else
        applyStimulus(1'b0, 1'b1, 8'd0);
        checkOutput(tag, 32'(bus.data_out), 32'(expWord));
`endif
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        bus.wen     = 1'b0;
        bus.ren     = 1'b0;
        bus.data_in = 8'd0;
        reset       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_count", 32'(bus.count), 32'd0);
        checkOutput("rst_empty", 32'(bus.empty), 32'd1);
        checkOutput("rst_ae", 32'(bus.almost_empty), 32'd1);
        checkOutput("rst_full", 32'(bus.full), 32'd0);
        checkOutput("rst_af", 32'(bus.almost_full), 32'd0);
        checkOutput("rst_ovf", 32'(bus.overflow), 32'd0);
        checkOutput("rst_udf", 32'(bus.underflow), 32'd0);
`ifndef FIFO_FWFT_EN
        checkOutput("rst_dout", 32'(bus.data_out), 32'd0);
`endif

        $display("[TB] fill and overflow");
        fillEight();
        applyStimulus(1'b1, 1'b0, 8'd22);
        checkOutput("ovf_pulse", 32'(bus.overflow), 32'd1);
        checkOutput("ovf_count", 32'(bus.count), 32'd8);
        checkOutput("ovf_full", 32'(bus.full), 32'd1);

        $display("[TB] drain and underflow");
        for (int i = 0; i < 8; i++) begin
            readCheck($sformatf("drain_data_%0d", i), fillVals[i]);
            if (i == 0) checkOutput("ovf_clear", 32'(bus.overflow), 32'd0);
            checkOutput($sformatf("drain_count_%0d", i), 32'(bus.count), 32'(drainCnt[i]));
            checkOutput($sformatf("drain_ae_%0d", i), 32'(bus.almost_empty), 32'(drainAe[i]));
            checkOutput($sformatf("drain_empty_%0d", i), 32'(bus.empty), 32'(drainEmp[i]));
        end
        applyStimulus(1'b0, 1'b1, 8'd0);
        checkOutput("udf_pulse", 32'(bus.underflow), 32'd1);
        checkOutput("udf_count", 32'(bus.count), 32'd0);
`ifndef FIFO_FWFT_EN
        checkOutput("udf_dout_hold", 32'(bus.data_out), 32'd9);
`endif
        applyStimulus(1'b0, 1'b0, 8'd0);
        checkOutput("udf_clear", 32'(bus.underflow), 32'd0);
`ifndef FIFO_FWFT_EN
        checkOutput("idle_dout_hold", 32'(bus.data_out), 32'd9);
`endif

        $display("[TB] simultaneous read/write at full");
        fillEight();
`ifdef FIFO_FWFT_EN
        checkOutput("sim_full_head", 32'(bus.data_out), 32'd10);
`endif
        applyStimulus(1'b1, 1'b1, 8'd220);
        checkOutput("sim_full_count", 32'(bus.count), 32'd8);
        checkOutput("sim_full_ovf", 32'(bus.overflow), 32'd0);
`ifndef FIFO_FWFT_EN
        checkOutput("sim_full_dout", 32'(bus.data_out), 32'd10);
`endif
        for (int i = 0; i < 8; i++) begin
            readCheck($sformatf("wrap_data_%0d", i), wrapVals[i]);
        end
        checkOutput("wrap_empty", 32'(bus.empty), 32'd1);

        $display("[TB] simultaneous read/write at empty");
        applyStimulus(1'b1, 1'b1, 8'd96);
        checkOutput("sim_empty_udf", 32'(bus.underflow), 32'd1);
        checkOutput("sim_empty_count", 32'(bus.count), 32'd1);
        checkOutput("sim_empty_empty", 32'(bus.empty), 32'd0);
        readCheck("sim_empty_data", 8'd96);
        checkOutput("sim_empty_drained", 32'(bus.count), 32'd0);

`ifdef FIFO_FWFT_EN
        $display("[TB] fall-through");
        applyStimulus(1'b1, 1'b0, 8'd155);
        checkOutput("fwft_data", 32'(bus.data_out), 32'd155);
        checkOutput("fwft_nonempty", 32'(bus.empty), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'd0);
        checkOutput("fwft_pop_empty", 32'(bus.empty), 32'd1);
`endif

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 1'b0, 8'd1);
        applyStimulus(1'b1, 1'b0, 8'd2);
        checkOutput("pre_rst_count", 32'(bus.count), 32'd2);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'd3);
        reset = 1'b0;
        checkOutput("mid_rst_count", 32'(bus.count), 32'd0);
        checkOutput("mid_rst_empty", 32'(bus.empty), 32'd1);
        checkOutput("mid_rst_udf", 32'(bus.underflow), 32'd0);
`ifndef FIFO_FWFT_EN
        checkOutput("mid_rst_dout", 32'(bus.data_out), 32'd0);
`endif
        applyStimulus(1'b1, 1'b0, 8'd77);
        readCheck("post_rst_data", 8'd77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
